tx_frame_arbiter: RTL and testbench



---
 rtl/tx_frame_arbiter_if.sv | 29 ++
 rtl/tx_frame_arbiter.sv | 130 +++++++++++++
 tb/tb_tx_frame_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_arbiter_if.sv
// Bundle of source-side and transmitter-side signals around the frame arbiter.
// master = the arbiter, slave = producers and the FT245 transmitter side.
interface tx_frame_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SOURCES    = 4
) ();
  localparam int SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [SOURCES*DATA_WIDTH-1:0] src_data;
  logic [SOURCES-1:0]            src_rdy;
  logic [SOURCES-1:0]            src_eof;
  logic [SOURCES-1:0]            src_ack;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_rdy;
  logic                          tx_ack;
  logic                          busy;
  logic [SRC_W-1:0]              grant_id;
  logic                          abort_o;

  modport master (
    input  src_data, src_rdy, src_eof, tx_ack,
    output src_ack, tx_data, tx_rdy, busy, grant_id, abort_o
  );

  modport slave (
    output src_data, src_rdy, src_eof, tx_ack,
    input  src_ack, tx_data, tx_rdy, busy, grant_id, abort_o
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin whole-frame arbiter from N transmit producers to the FT245 transmitter,
// with optional source-ID header word and stall-timeout abort.
module tx_frame_arbiter #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    SOURCES        = 4,
  parameter bit                    HEADER_EN      = 1'b1,
  parameter logic [DATA_WIDTH-1:0] HDR_BASE       = 8'hF0,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  tx_frame_arbiter_if.master bus
);
  localparam int SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [SRC_W-1:0]  grant_reg, grant_next;
  logic [SRC_W-1:0]  last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic              abort_reg, abort_next;

  logic [DATA_WIDTH-1:0] src_word [SOURCES];
  logic                  sel_rdy;
  logic                  sel_eof;
  logic                  pick_valid;
  logic [SRC_W-1:0]      pick_idx;
  logic [SRC_W-1:0]      cand;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_rdy;
  logic [SOURCES-1:0]    src_ack;

  generate
    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_unpack
      assign src_word[gi] = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign sel_rdy = bus.src_rdy[grant_reg];
  assign sel_eof = bus.src_eof[grant_reg];

  // First ready source strictly after the previous winner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= SOURCES; k++) begin
      cand = SRC_W'((int'(last_grant_reg) + k) % SOURCES);
      if (!pick_valid && bus.src_rdy[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= SRC_W'(SOURCES - 1);
      stall_cnt_reg  <= '0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      stall_cnt_reg  <= stall_cnt_next;
      abort_reg      <= abort_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    stall_cnt_next  = '0;
    abort_next      = 1'b0;
    tx_data         = '0;
    tx_rdy          = 1'b0;
    src_ack         = '0;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_idx;
          state_next = HEADER_EN ? HEADER : STREAM;
        end
      end

      HEADER: begin
        tx_data = HDR_BASE + DATA_WIDTH'(grant_reg);
        tx_rdy  = 1'b1;
        if (bus.tx_ack) begin
          state_next = STREAM;
        end
      end

      STREAM: begin
        tx_data           = src_word[grant_reg];
        tx_rdy            = sel_rdy;
        src_ack[grant_reg] = bus.tx_ack && sel_rdy;
        if (sel_rdy) begin
          if (bus.tx_ack && sel_eof) begin
            last_grant_next = grant_reg;
            state_next      = IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0 && stall_cnt_reg == STALL_LAST) begin
          // Stalled source gives up its turn so the others are not starved.
          last_grant_next = grant_reg;
          state_next      = IDLE;
          abort_next      = 1'b1;
        end else begin
          stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.tx_data  = tx_data;
  assign bus.tx_rdy   = tx_rdy;
  assign bus.src_ack  = src_ack;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.grant_id = grant_reg;
  assign bus.abort_o  = abort_reg;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench: table of per-cycle vectors on a header/timeout-16 instance,
// plus a hand-written sequence on a header-less instance.
module tb_tx_frame_arbiter;
  logic clk;
  logic rst1;
  logic rst2;
  int   checks;
  int   errors;

  typedef struct {
    logic        chk;
    logic        rst;
    logic [3:0]  rdy;
    logic [3:0]  eof;
    logic [31:0] data;
    logic        ack;
    logic        e_rdy;
    logic [7:0]  e_data;
    logic [3:0]  e_sack;
    logic        e_busy;
    logic [1:0]  e_grant;
    logic        e_abort;
  } vec_t;

  vec_t tbl[$];

  tx_frame_arbiter_if #(.DATA_WIDTH(8), .SOURCES(4)) bus1 ();
  tx_frame_arbiter_if #(.DATA_WIDTH(8), .SOURCES(4)) bus2 ();

  tx_frame_arbiter #(
    .DATA_WIDTH(8), .SOURCES(4), .HEADER_EN(1'b1), .HDR_BASE(8'hF0), .TIMEOUT_CYCLES(16)
  ) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1.master)
  );

  tx_frame_arbiter #(
    .DATA_WIDTH(8), .SOURCES(4), .HEADER_EN(1'b0), .HDR_BASE(8'hF0), .TIMEOUT_CYCLES(1024)
  ) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic chk, input logic rst, input logic [3:0] rdy,
                              input logic [3:0] eof, input logic [31:0] data, input logic ack,
                              input logic e_rdy, input logic [7:0] e_data, input logic [3:0] e_sack,
                              input logic e_busy, input logic [1:0] e_grant, input logic e_abort);
    vec_t v;
    v.chk = chk; v.rst = rst; v.rdy = rdy; v.eof = eof; v.data = data; v.ack = ack;
    v.e_rdy = e_rdy; v.e_data = e_data; v.e_sack = e_sack;
    v.e_busy = e_busy; v.e_grant = e_grant; v.e_abort = e_abort;
    tbl.push_back(v);
  endfunction

  // Idle cycle: nothing offered to the transmitter, no acks.
  function automatic void addi(input logic rst, input logic [3:0] rdy, input logic [3:0] eof,
                               input logic [31:0] data, input logic ack,
                               input logic [1:0] grant, input logic abort);
    add(1'b1, rst, rdy, eof, data, ack, 1'b0, 8'h00, 4'h0, 1'b0, grant, abort);
  endfunction

  function automatic void build();
    // Reset state
    add(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 0, 0, 0, 0, 0, 0);
    addi(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    // Source 1 frame A1,B2,C3 with header F1, ack one cycle after tx_rdy
    addi(1'b0, 4'b0010, 4'h0, 32'h0000_A100, 1'b0, 2'd0, 1'b0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_A100, 0, 1, 8'hF1, 4'h0, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_A100, 1, 1, 8'hF1, 4'h0, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_A100, 0, 1, 8'hA1, 4'h0, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_A100, 1, 1, 8'hA1, 4'b0010, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_B200, 0, 1, 8'hB2, 4'h0, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'h0, 32'h0000_B200, 1, 1, 8'hB2, 4'b0010, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'b0010, 32'h0000_C300, 0, 1, 8'hC3, 4'h0, 1, 2'd1, 0);
    add(1, 0, 4'b0010, 4'b0010, 32'h0000_C300, 1, 1, 8'hC3, 4'b0010, 1, 2'd1, 0);
    addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd1, 1'b0);
    // Fresh reset, then all four sources offer 1-word frames forever
    add(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 0, 0, 0, 0, 0, 0);
    addi(1'b0, 4'hF, 4'hF, 32'h1312_1110, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      int s;
      s = k % 4;
      add(1, 0, 4'hF, 4'hF, 32'h1312_1110, 1, 1, 8'(8'hF0 + s), 4'h0, 1, 2'(s), 0);
      add(1, 0, 4'hF, 4'hF, 32'h1312_1110, 1, 1, 8'(8'h10 + s), 4'(1 << s), 1, 2'(s), 0);
      if (k < 5) addi(1'b0, 4'hF, 4'hF, 32'h1312_1110, 1'b1, 2'(s), 1'b0);
      else       addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'(s), 1'b0);
    end
    // Backpressure: tx_ack withheld five cycles mid-frame on source 2
    addi(1'b0, 4'b0100, 4'h0, 32'h005C_0000, 1'b0, 2'd1, 1'b0);
    add(1, 0, 4'b0100, 4'h0, 32'h005C_0000, 1, 1, 8'hF2, 4'h0, 1, 2'd2, 0);
    for (int k = 0; k < 5; k++)
      add(1, 0, 4'b0100, 4'h0, 32'h005C_0000, 0, 1, 8'h5C, 4'h0, 1, 2'd2, 0);
    add(1, 0, 4'b0100, 4'h0, 32'h005C_0000, 1, 1, 8'h5C, 4'b0100, 1, 2'd2, 0);
    add(1, 0, 4'b0100, 4'b0100, 32'h006D_0000, 1, 1, 8'h6D, 4'b0100, 1, 2'd2, 0);
    addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd2, 1'b0);
    // Timeout: source 2 stalls mid-frame while source 3 waits
    addi(1'b0, 4'b0100, 4'h0, 32'h0077_0000, 1'b0, 2'd2, 1'b0);
    add(1, 0, 4'b0100, 4'h0, 32'h0077_0000, 1, 1, 8'hF2, 4'h0, 1, 2'd2, 0);
    add(1, 0, 4'b0100, 4'h0, 32'h0077_0000, 1, 1, 8'h77, 4'b0100, 1, 2'd2, 0);
    for (int k = 0; k < 16; k++)
      add(1, 0, 4'b1000, 4'b1000, 32'h3377_0000, 1, 0, 8'h77, 4'h0, 1, 2'd2, 0);
    addi(1'b0, 4'b1000, 4'b1000, 32'h3377_0000, 1'b0, 2'd2, 1'b1);
    add(1, 0, 4'b1000, 4'b1000, 32'h3377_0000, 1, 1, 8'hF3, 4'h0, 1, 2'd3, 0);
    add(1, 0, 4'b1000, 4'b1000, 32'h3377_0000, 1, 1, 8'h33, 4'b1000, 1, 2'd3, 0);
    addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd3, 1'b0);
    // Reset during the second word of a source 3 frame, sources 0 and 3 ready
    addi(1'b0, 4'b1000, 4'h0, 32'h3100_0000, 1'b0, 2'd3, 1'b0);
    add(1, 0, 4'b1000, 4'h0, 32'h3100_0000, 1, 1, 8'hF3, 4'h0, 1, 2'd3, 0);
    add(1, 0, 4'b1000, 4'h0, 32'h3100_0000, 1, 1, 8'h31, 4'b1000, 1, 2'd3, 0);
    add(1, 1, 4'b1001, 4'h0, 32'h3200_000A, 0, 1, 8'h32, 4'h0, 1, 2'd3, 0);
    addi(1'b0, 4'b1001, 4'h0, 32'h3200_000A, 1'b0, 2'd0, 1'b0);
    add(1, 0, 4'b1001, 4'h0, 32'h3200_000A, 1, 1, 8'hF0, 4'h0, 1, 2'd0, 0);
    add(1, 0, 4'b1001, 4'b0001, 32'h3200_000A, 1, 1, 8'h0A, 4'b0001, 1, 2'd0, 0);
    addi(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply1(input vec_t v, input int idx);
    rst1          = v.rst;
    bus1.src_rdy  = v.rdy;
    bus1.src_eof  = v.eof;
    bus1.src_data = v.data;
    bus1.tx_ack   = v.ack;
    @(negedge clk);
    if (v.chk) begin
      check("tx_rdy",   idx, 32'(bus1.tx_rdy),   32'(v.e_rdy));
      check("tx_data",  idx, 32'(bus1.tx_data),  32'(v.e_data));
      check("src_ack",  idx, 32'(bus1.src_ack),  32'(v.e_sack));
      check("busy",     idx, 32'(bus1.busy),     32'(v.e_busy));
      check("grant_id", idx, 32'(bus1.grant_id), 32'(v.e_grant));
      check("abort_o",  idx, 32'(bus1.abort_o),  32'(v.e_abort));
    end
    $display("vec %0d rst=%0b rdy=%h ack=%0b -> tx_rdy=%0b tx_data=%h src_ack=%h busy=%0b grant=%0d abort=%0b",
             idx, v.rst, v.rdy, v.ack, bus1.tx_rdy, bus1.tx_data, bus1.src_ack,
             bus1.busy, bus1.grant_id, bus1.abort_o);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input string tag, input logic rst, input logic [3:0] rdy, input logic [3:0] eof,
                      input logic [31:0] data, input logic ack,
                      input logic e_rdy, input logic [7:0] e_data, input logic [3:0] e_sack,
                      input logic e_busy, input logic [1:0] e_grant);
    rst2          = rst;
    bus2.src_rdy  = rdy;
    bus2.src_eof  = eof;
    bus2.src_data = data;
    bus2.tx_ack   = ack;
    @(negedge clk);
    check({tag, ".tx_rdy"},   0, 32'(bus2.tx_rdy),   32'(e_rdy));
    check({tag, ".tx_data"},  0, 32'(bus2.tx_data),  32'(e_data));
    check({tag, ".src_ack"},  0, 32'(bus2.src_ack),  32'(e_sack));
    check({tag, ".busy"},     0, 32'(bus2.busy),     32'(e_busy));
    check({tag, ".grant_id"}, 0, 32'(bus2.grant_id), 32'(e_grant));
    check({tag, ".abort_o"},  0, 32'(bus2.abort_o),  32'(1'b0));
    $display("%s: tx_rdy=%0b tx_data=%h src_ack=%h busy=%0b grant=%0d",
             tag, bus2.tx_rdy, bus2.tx_data, bus2.src_ack, bus2.busy, bus2.grant_id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst1 = 1'b1; rst2 = 1'b1;
    bus1.src_rdy = '0; bus1.src_eof = '0; bus1.src_data = '0; bus1.tx_ack = 1'b0;
    bus2.src_rdy = '0; bus2.src_eof = '0; bus2.src_data = '0; bus2.tx_ack = 1'b0;
    build();
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply1(tbl[i], i);

    // Header-less instance: 5A passes through the cycle after the grant decision
    cyc2("nh_reset", 1, 4'h0,    4'h0,    32'h0,         0, 0, 8'h00, 4'h0,    0, 2'd0);
    cyc2("nh_req",   0, 4'b0001, 4'b0001, 32'h0000_005A, 0, 0, 8'h00, 4'h0,    0, 2'd0);
    cyc2("nh_xfer",  0, 4'b0001, 4'b0001, 32'h0000_005A, 1, 1, 8'h5A, 4'b0001, 1, 2'd0);
    cyc2("nh_idle",  0, 4'h0,    4'h0,    32'h0,         0, 0, 8'h00, 4'h0,    0, 2'd0);
    cyc2("nh_req2",  0, 4'b0100, 4'b0100, 32'h00C7_0000, 0, 0, 8'h00, 4'h0,    0, 2'd0);
    cyc2("nh_hold2", 0, 4'b0100, 4'b0100, 32'h00C7_0000, 0, 1, 8'hC7, 4'h0,    1, 2'd2);
    cyc2("nh_xfer2", 0, 4'b0100, 4'b0100, 32'h00C7_0000, 1, 1, 8'hC7, 4'b0100, 1, 2'd2);
    cyc2("nh_idle2", 0, 4'h0,    4'h0,    32'h0,         0, 0, 8'h00, 4'h0,    0, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
